sprite_motion_engine: RTL and testbench

// - Parametrised successor to the single-sprite mover: owns one sprite's position, applies a
//   per-frame move command with a selectable edge policy, then erases the old box and redraws
//   the sprite pixel-by-pixel to the VGA framebuffer write port.
// - Sprite pixels are read from an external pattern ROM with 1-cycle latency; a key colour is

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/sprite_motion_engine_raster_scan.sv | 38 +++
 rtl/sprite_motion_engine.sv | 186 ++++++++++++++++++
 tb/tb_sprite_motion_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite motion engine: edge policies, FSM encoding,
// direction bit positions and a per-axis step helper.
package sprite_pkg;
  localparam int EDGE_CLAMP = 0;
  localparam int EDGE_WRAP  = 1;
  localparam int EDGE_EXIT  = 2;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERASE = 3'd1,
    S_MOVE  = 3'd2,
    S_DRAW  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Opposing direction bits cancel, so only a lone bit yields a step.
  function automatic int axis_delta(input logic neg_bit, input logic pos_bit, input int step);
    if (pos_bit && !neg_bit) return step;
    if (neg_bit && !pos_bit) return -step;
    return 0;
  endfunction
endpackage

// File: rtl/sprite_motion_engine_raster_scan.sv
// Row-major (column fastest) scan counter over the sprite box; wraps to the
// origin after the last pixel is stepped past.
module raster_scan #(
  parameter int SPR_W = 15,
  parameter int SPR_H = 10,
  parameter int CW    = 8,
  parameter int RW    = 7
) (
  input  logic          i_clk,
  input  logic          i_clear,
  input  logic          i_step,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_last
);
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_end;

  assign w_col_end = (r_col == CW'(SPR_W - 1));
  assign o_last    = w_col_end && (r_row == RW'(SPR_H - 1));
  assign o_col     = r_col;
  assign o_row     = r_row;

  always_ff @(posedge i_clk) begin
    if (i_clear || (i_step && o_last)) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_step) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_motion_engine.sv
// One on-screen sprite: erase old box, apply a move with an edge policy, then
// redraw from a 1-cycle-latency pattern ROM with a transparent key colour.
module sprite_motion_engine
  import sprite_pkg::*;
#(
  parameter int             SCREEN_W   = 160,
  parameter int             SCREEN_H   = 120,
  parameter int             SPR_W      = 15,
  parameter int             SPR_H      = 10,
  parameter int             X_W        = 8,
  parameter int             Y_W        = 7,
  parameter int             STEP       = 1,
  parameter int             EDGE_MODE  = EDGE_CLAMP,
  parameter int             INIT_X     = 80,
  parameter int             INIT_Y     = 60,
  parameter int             COL_W      = 3,
  parameter logic [COL_W-1:0] BG_COLOUR  = COL_W'(0),
  parameter logic [COL_W-1:0] KEY_COLOUR = COL_W'(5)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [3:0]       i_dir,
  input  logic             i_respawn,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_left_screen,
  output logic             o_plot,
  output logic [X_W-1:0]   o_x_out,
  output logic [Y_W-1:0]   o_y_out,
  output logic [COL_W-1:0] o_colour_out,
  output logic [4:0]       o_pat_x,
  output logic [3:0]       o_pat_y,
  input  logic [COL_W-1:0] i_pat_colour,
  output logic [X_W-1:0]   o_pos_x,
  output logic [Y_W-1:0]   o_pos_y
);
  localparam logic [X_W-1:0] MAX_X = X_W'(SCREEN_W - SPR_W);
  localparam logic [Y_W-1:0] MAX_Y = Y_W'(SCREEN_H - SPR_H);

  state_t r_state, w_next;

  logic [X_W-1:0] r_pos_x, r_pcol, w_col, w_mx;
  logic [Y_W-1:0] r_pos_y, r_prow, w_row, w_my;
  logic [3:0]     r_dir;
  logic           r_respawn, r_left, r_pix_vld, r_addr_done;
  logic           w_last, w_clear, w_step, w_issue;

  logic signed [X_W:0] w_dx, w_nx;
  logic signed [Y_W:0] w_dy, w_ny;
  logic w_xlo, w_xhi, w_ylo, w_yhi;

  raster_scan #(.SPR_W(SPR_W), .SPR_H(SPR_H), .CW(X_W), .RW(Y_W)) u_scan (
    .i_clk  (i_clk),
    .i_clear(w_clear | i_reset),
    .i_step (w_step),
    .o_col  (w_col),
    .o_row  (w_row),
    .o_last (w_last)
  );

  // Candidate position in one extra signed bit so both underflow and overflow are visible.
  always_comb begin
    w_dx  = (X_W+1)'(axis_delta(r_dir[DIR_LEFT], r_dir[DIR_RIGHT], STEP));
    w_dy  = (Y_W+1)'(axis_delta(r_dir[DIR_UP],   r_dir[DIR_DOWN],  STEP));
    w_nx  = $signed({1'b0, r_pos_x}) + w_dx;
    w_ny  = $signed({1'b0, r_pos_y}) + w_dy;
    w_xlo = w_nx[X_W];
    w_ylo = w_ny[Y_W];
    w_xhi = w_nx > $signed({1'b0, MAX_X});
    w_yhi = w_ny > $signed({1'b0, MAX_Y});
    w_mx  = w_nx[X_W-1:0];
    w_my  = w_ny[Y_W-1:0];
    if (EDGE_MODE == EDGE_WRAP) begin
      if (w_xlo) w_mx = MAX_X; else if (w_xhi) w_mx = '0;
      if (w_ylo) w_my = MAX_Y; else if (w_yhi) w_my = '0;
    end else begin
      if (w_xlo) w_mx = '0; else if (w_xhi) w_mx = MAX_X;
      if (w_ylo) w_my = '0; else if (w_yhi) w_my = MAX_Y;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_clear      = 1'b0;
    w_step       = 1'b0;
    w_issue      = 1'b0;
    o_plot       = 1'b0;
    o_x_out      = '0;
    o_y_out      = '0;
    o_colour_out = '0;
    o_pat_x      = '0;
    o_pat_y      = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next  = S_ERASE;
          w_clear = 1'b1;
        end
      end
      S_ERASE: begin
        o_plot       = 1'b1;
        o_x_out      = r_pos_x + w_col;
        o_y_out      = r_pos_y + w_row;
        o_colour_out = BG_COLOUR;
        w_step       = 1'b1;
        if (w_last) w_next = S_MOVE;
      end
      S_MOVE: begin
        w_clear = 1'b1;
        w_next  = S_DRAW;
      end
      S_DRAW: begin
        // Address stage runs one cycle ahead of the pixel output stage.
        w_issue = !r_addr_done;
        w_step  = w_issue;
        if (w_issue) begin
          o_pat_x = 5'(w_col);
          o_pat_y = 4'(w_row);
        end
        if (r_pix_vld) begin
          o_x_out      = r_pos_x + r_pcol;
          o_y_out      = r_pos_y + r_prow;
          o_colour_out = i_pat_colour;
          o_plot       = (i_pat_colour != KEY_COLOUR);
          if (r_addr_done) w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pos_x     <= X_W'(INIT_X);
      r_pos_y     <= Y_W'(INIT_Y);
      r_dir       <= '0;
      r_respawn   <= 1'b0;
      r_left      <= 1'b0;
      r_pix_vld   <= 1'b0;
      r_addr_done <= 1'b0;
      r_pcol      <= '0;
      r_prow      <= '0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_dir     <= i_dir;
        r_respawn <= i_respawn;
      end
      if (r_state == S_MOVE) begin
        r_pix_vld   <= 1'b0;
        r_addr_done <= 1'b0;
        if (r_respawn) begin
          r_pos_x <= X_W'(INIT_X);
          r_pos_y <= Y_W'(INIT_Y);
          r_left  <= 1'b0;
        end else if (EDGE_MODE == EDGE_EXIT && (w_xlo || w_xhi || w_ylo || w_yhi)) begin
          r_pos_x <= X_W'(INIT_X);
          r_pos_y <= Y_W'(INIT_Y);
          r_left  <= 1'b1;
        end else begin
          r_pos_x <= w_mx;
          r_pos_y <= w_my;
        end
      end
      if (r_state == S_DRAW) begin
        r_pix_vld <= w_issue;
        r_pcol    <= w_col;
        r_prow    <= w_row;
        if (w_issue && w_last) r_addr_done <= 1'b1;
      end
      if (r_state == S_DONE) r_left <= 1'b0;
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_left_screen = r_left;
  assign o_pos_x       = r_pos_x;
  assign o_pos_y       = r_pos_y;
endmodule

// File: tb/tb_sprite_motion_engine.sv
// Directed bench: default CLAMP engine with a pattern ROM model, plus three
// edge-policy instances (CLAMP at right bound, WRAP at corner, EXIT with big step).
module tb_sprite_motion_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, respawn;
  logic [3:0] dir;
  logic [2:0] pat_colour;
  logic       busy, done, left_s, plot;
  logic [7:0] x_out, pos_x;
  logic [6:0] y_out, pos_y;
  logic [2:0] colour;
  logic [4:0] pat_x;
  logic [3:0] pat_y;

  int n_cmp = 0;
  int n_bad = 0;

  sprite_motion_engine u_dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_dir(dir), .i_respawn(respawn),
    .o_busy(busy), .o_done(done), .o_left_screen(left_s), .o_plot(plot),
    .o_x_out(x_out), .o_y_out(y_out), .o_colour_out(colour),
    .o_pat_x(pat_x), .o_pat_y(pat_y), .i_pat_colour(pat_colour),
    .o_pos_x(pos_x), .o_pos_y(pos_y)
  );

  // Pattern ROM: column 0 is the key colour, everything else is in 0..3.
  function automatic logic [2:0] rom(input int c, input int r);
    if (c == 0) return 3'b101;
    return 3'((c + r) % 4);
  endfunction

  always @(posedge clk) pat_colour <= rom(int'(pat_x), int'(pat_y));

  // Edge instances: 0 = CLAMP at x=145, 1 = WRAP at (0,110), 2 = EXIT with STEP 15.
  logic [2:0] e_start;
  logic [3:0] e_dir;
  logic [2:0] e_pat = 3'b001;
  logic       e_busy[3], e_done[3], e_left[3], e_plot[3];
  logic [7:0] e_xo[3], e_px[3];
  logic [6:0] e_yo[3], e_py[3];
  logic [2:0] e_col[3];
  logic [4:0] e_patx[3];
  logic [3:0] e_paty[3];

  for (genvar g = 0; g < 3; g++) begin : g_edge
    sprite_motion_engine #(
      .EDGE_MODE(g),
      .INIT_X   (g == 0 ? 145 : (g == 1 ? 0 : 80)),
      .INIT_Y   (g == 1 ? 110 : 60),
      .STEP     (g == 2 ? 15 : 1)
    ) u_e (
      .i_clk(clk), .i_reset(reset), .i_start(e_start[g]), .i_dir(e_dir), .i_respawn(1'b0),
      .o_busy(e_busy[g]), .o_done(e_done[g]), .o_left_screen(e_left[g]), .o_plot(e_plot[g]),
      .o_x_out(e_xo[g]), .o_y_out(e_yo[g]), .o_colour_out(e_col[g]),
      .o_pat_x(e_patx[g]), .o_pat_y(e_paty[g]), .i_pat_colour(e_pat),
      .o_pos_x(e_px[g]), .o_pos_y(e_py[g])
    );
  end

  // Runs one frame on the main engine; lat = cycle index of done (-1 on timeout).
  // Returns in the IDLE cycle that follows DONE.
  task automatic run_main(input logic [3:0] d, input logic r, output int lat);
    int t;
    @(negedge clk);
    dir = d; respawn = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0; t = 1;
    while (!done && t < 400) begin @(negedge clk); t++; end
    lat = done ? t : -1;
    @(negedge clk);
  endtask

  task automatic run_edge(input int w, input logic [3:0] d, output int lat, output logic lft);
    int t;
    @(negedge clk);
    e_dir = d; e_start[w] = 1'b1;
    @(negedge clk);
    e_start = '0; t = 1;
    while (!e_done[w] && t < 400) begin @(negedge clk); t++; end
    lat = e_done[w] ? t : -1;
    lft = e_left[w];
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; respawn = 1'b0; dir = '0; e_start = '0; e_dir = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, left_s, plot} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, left_s, plot});
    end
    n_cmp++;
    if ({x_out, y_out, colour, pat_x, pat_y} !== 27'd0) begin
      n_bad++; $display("FAIL reset_outs: got x=%0d y=%0d c=%0d px=%0d py=%0d want all 0",
                        x_out, y_out, colour, pat_x, pat_y);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pos_x !== 8'd80 || pos_y !== 7'd60) begin
      n_bad++; $display("FAIL reset_pos: got (%0d,%0d) want (80,60)", pos_x, pos_y);
    end
  endtask

  task automatic test_first_frame();
    int erase_bad = 0, erase_plots = 0, draw_bad = 0, draw_plots = 0, addr_bad = 0;
    int pos_bad = 0, idle_bad = 0, done_at = -1;
    int k, p, c, r;
    @(negedge clk);
    dir = 4'b0001; respawn = 1'b0; start = 1'b1;
    for (int t = 1; t <= 312; t++) begin
      @(negedge clk);
      start = (t == 10 || t == 200);
      if (t >= 1 && t <= 150) begin
        p = t - 1;
        if (plot) erase_plots++;
        if (!(plot === 1'b1 && x_out === 8'(80 + p % 15) && y_out === 7'(60 + p / 15) &&
              colour === 3'b000)) erase_bad++;
        if (pos_x !== 8'd80) pos_bad++;
      end
      if (t == 151 && (plot !== 1'b0 || busy !== 1'b1)) erase_bad++;
      if (t >= 152 && t <= 302) begin
        k = t - 152;
        if (k < 150 && (pat_x !== 5'(k % 15) || pat_y !== 4'(k / 15))) addr_bad++;
        if (k == 0 && plot !== 1'b0) draw_bad++;
        if (k >= 1) begin
          p = k - 1; c = p % 15; r = p / 15;
          if (plot) draw_plots++;
          if (plot !== (c != 0)) draw_bad++;
          else if (c != 0 && (x_out !== 8'(81 + c) || y_out !== 7'(60 + r) || colour !== rom(c, r)))
            draw_bad++;
        end
        if (pos_x !== 8'd81 || pos_y !== 7'd60) pos_bad++;
      end
      if (done === 1'b1 && done_at < 0) done_at = t;
      if (t == 303 && (plot !== 1'b0 || busy !== 1'b1)) draw_bad++;
      if (t >= 304 && (busy !== 1'b0 || done !== 1'b0 || plot !== 1'b0)) idle_bad++;
    end
    start = 1'b0;
    n_cmp++;
    if (erase_plots !== 150 || erase_bad !== 0) begin
      n_bad++; $display("FAIL erase_scan: got %0d plots %0d bad want 150 plots 0 bad", erase_plots, erase_bad);
    end
    n_cmp++;
    if (addr_bad !== 0) begin
      n_bad++; $display("FAIL draw_addr: got %0d bad cycles want 0", addr_bad);
    end
    n_cmp++;
    if (draw_plots !== 140 || draw_bad !== 0) begin
      n_bad++; $display("FAIL draw_pixels: got %0d plots %0d bad want 140 plots 0 bad", draw_plots, draw_bad);
    end
    n_cmp++;
    if (pos_bad !== 0) begin
      n_bad++; $display("FAIL pos_timing: got %0d bad cycles want 0", pos_bad);
    end
    n_cmp++;
    if (done_at !== 303) begin
      n_bad++; $display("FAIL done_latency: got %0d want 303", done_at);
    end
    n_cmp++;
    if (idle_bad !== 0) begin
      n_bad++; $display("FAIL busy_start_ignored: got %0d bad idle cycles want 0", idle_bad);
    end
  endtask

  task automatic test_move_main();
    int lat;
    run_main(4'b0011, 1'b0, lat);
    n_cmp++;
    if (lat !== 303 || pos_x !== 8'd81 || pos_y !== 7'd60) begin
      n_bad++; $display("FAIL cancel_lr: got lat=%0d (%0d,%0d) want 303 (81,60)", lat, pos_x, pos_y);
    end
    run_main(4'b0101, 1'b0, lat);
    n_cmp++;
    if (pos_x !== 8'd82 || pos_y !== 7'd61) begin
      n_bad++; $display("FAIL diag_move: got (%0d,%0d) want (82,61)", pos_x, pos_y);
    end
    run_main(4'b0101, 1'b1, lat);
    n_cmp++;
    if (pos_x !== 8'd80 || pos_y !== 7'd60 || left_s !== 1'b0) begin
      n_bad++; $display("FAIL respawn: got (%0d,%0d) left=%b want (80,60) left=0", pos_x, pos_y, left_s);
    end
  endtask

  task automatic test_clamp();
    int lat; logic lft;
    run_edge(0, 4'b0001, lat, lft);
    n_cmp++;
    if (lat !== 303 || e_px[0] !== 8'd145 || e_py[0] !== 7'd60) begin
      n_bad++; $display("FAIL clamp_right: got lat=%0d (%0d,%0d) want 303 (145,60)", lat, e_px[0], e_py[0]);
    end
  endtask

  task automatic test_wrap();
    int lat; logic lft;
    run_edge(1, 4'b0010, lat, lft);
    n_cmp++;
    if (e_px[1] !== 8'd145 || e_py[1] !== 7'd110) begin
      n_bad++; $display("FAIL wrap_left: got (%0d,%0d) want (145,110)", e_px[1], e_py[1]);
    end
    run_edge(1, 4'b0100, lat, lft);
    n_cmp++;
    if (e_px[1] !== 8'd145 || e_py[1] !== 7'd0) begin
      n_bad++; $display("FAIL wrap_down: got (%0d,%0d) want (145,0)", e_px[1], e_py[1]);
    end
  endtask

  task automatic test_exit();
    int lat; logic lft;
    for (int i = 0; i < 4; i++) run_edge(2, 4'b1000, lat, lft);
    n_cmp++;
    if (e_py[2] !== 7'd0 || e_px[2] !== 8'd80 || lft !== 1'b0) begin
      n_bad++; $display("FAIL exit_approach: got (%0d,%0d) left=%b want (80,0) left=0", e_px[2], e_py[2], lft);
    end
    run_edge(2, 4'b1000, lat, lft);
    n_cmp++;
    if (lft !== 1'b1 || lat !== 303) begin
      n_bad++; $display("FAIL exit_flag: got left=%b lat=%0d want left=1 lat=303", lft, lat);
    end
    n_cmp++;
    if (e_left[2] !== 1'b0 || e_px[2] !== 8'd80 || e_py[2] !== 7'd60) begin
      n_bad++; $display("FAIL exit_respawn: got left=%b (%0d,%0d) want left=0 (80,60)", e_left[2], e_px[2], e_py[2]);
    end
  endtask

  task automatic test_mid_reset();
    int quiet_bad = 0;
    @(negedge clk);
    dir = 4'b0001; respawn = 1'b0; start = 1'b1;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_cmp++;
    if (pos_x !== 8'd81 || busy !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_draw: got pos_x=%0d busy=%b want 81 1", pos_x, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (plot !== 1'b0 || busy !== 1'b0 || pos_x !== 8'd80 || pos_y !== 7'd60) begin
      n_bad++; $display("FAIL mid_reset: got plot=%b busy=%b (%0d,%0d) want 0 0 (80,60)",
                        plot, busy, pos_x, pos_y);
    end
    repeat (20) begin
      @(negedge clk);
      if (plot !== 1'b0 || busy !== 1'b0) quiet_bad++;
    end
    n_cmp++;
    if (quiet_bad !== 0) begin
      n_bad++; $display("FAIL post_reset_quiet: got %0d active cycles want 0", quiet_bad);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_move_main();
    test_clamp();
    test_wrap();
    test_exit();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
